qos_rr_arbiter: RTL and testbench
=================================

Name: qos_rr_arbiter

Overview:
- N-master QoS arbiter for one AXI address channel (AW or AR); next generation of the 2-master QoS write-address arbiter.
- Highest effective QoS wins. Ties go to the next master in round-robin order after the last winner.
- Per-master aging counters promote starved requesters to top priority.
- The grant is registered and held stable until the downstream handshake completes. Sits between the master-side address ports and the address-channel mux/decoder.

Parameters:
- NUM_MASTERS, 4: number of requesting masters, 2..16.
- ID_W, $clog2(NUM_MASTERS): width of grant_id.
- QOS_W, 4: width of each QoS field.
- AGE_W, 4: width of each per-master age counter.
- AGE_LIMIT, 8: wait cycles after which a requester is promoted; 1..2^AGE_W-1.
- QOS_EN, 1: 1 = QoS plus round-robin; 0 = pure round-robin (QoS ignored).

Ports:
- ACLK  in  1  clock.
- ARESETN  in  1  async active-low reset.
- req_valid  in  NUM_MASTERS  per-master AxVALID.
- req_qos  in  NUM_MASTERS*QOS_W  per-master AxQOS; master i occupies bits [i*QOS_W +: QOS_W].
- grant_ready  in  1  downstream accepted the granted address (AxREADY of the selected path).
- grant_valid  out  1  a grant is active.
- grant_id  out  ID_W  index of the granted master.
- grant_onehot  out  NUM_MASTERS  one-hot form of grant_id; all zeros when grant_valid=0.
- promoted  out  NUM_MASTERS  per-master flag, age >= AGE_LIMIT (debug/perf).

Behaviour:
- Reset: ARESETN is asynchronous, active-low; clock is ACLK.
  - On reset: grant_valid=0, grant_id=0, grant_onehot=0, promoted=0, all age counters=0, rr_ptr=0, state=ARB.
  - Reset asserted mid-grant drops the grant immediately. No handshake is reported for it.
- FSM has two states: ARB and GRANT.
  - ARB: if any req_valid, latch the winner into grant_id/grant_onehot, set grant_valid=1 on the next edge, go to GRANT. Otherwise stay in ARB.
  - GRANT: grant_id, grant_onehot and grant_valid are held stable until grant_valid && grant_ready at a rising edge.
  - On that handshake: grant_valid=0, rr_ptr = (grant_id+1) mod NUM_MASTERS, winner's age cleared, return to ARB.
  - Result: one bubble cycle between consecutive grants; request-to-grant latency is 1 cycle.
- Effective priority of master i is a (QOS_W+1)-bit value:
  - promoted[i] ? {1'b1, QOS_W zeros} : {1'b0, req_qos[i]}.
  - With QOS_EN=0 the QoS part is forced to 0, so only promotion and round-robin apply.
- Winner selection:
  - Among masters with req_valid=1, highest effective priority wins.
  - Ties: first master found scanning from rr_ptr upward with wrap-around (rr_ptr, rr_ptr+1, ..., NUM_MASTERS-1, 0, ...).
  - Multiple promoted masters tie at max priority and resolve by round-robin.
- Age counters, per master, updated every cycle:
  - req_valid=0: cleared to 0.
  - req_valid=1 and master is the current granted master (state GRANT): held.
  - Otherwise with req_valid=1: incremented, saturating at 2^AGE_W-1. No wrap.
- promoted[i] = age[i] >= AGE_LIMIT; it is a combinational decode of registered age.
- Granted master dropping req_valid while in GRANT (AXI violation): grant is still held until grant_ready. Arbiter does not re-arbitrate.
- grant_ready while grant_valid=0 is ignored.
- Single requester: always wins regardless of QoS or rr_ptr.

Test Plan:
- Reset with req_valid=4'b1111 held, then release ARESETN -> grant_valid=0 during reset; first grant 1 cycle after release; grant_id=0 with all qos equal (rr_ptr=0).
- req_valid=4'b0110, qos[1]=3, qos[2]=9, grant_ready=1 -> grant_id=2; next grant after the bubble cycle is grant_id=1.
- All 4 masters valid, equal qos=5, grant_ready pulsed at every grant -> grant order 0,1,2,3,0.
- grant_ready held low 20 cycles in GRANT -> grant_id/onehot stable all 20 cycles; handshake on cycle 21 produces a single rr_ptr update.
- Master 0 qos=15 continuously, master 3 qos=0 continuously, AGE_LIMIT=8 -> promoted[3] asserts after 8 non-granted wait cycles; master 3 is granted at the next arbitration; its age then clears to 0.
- QOS_EN=0, masters 1 and 3 valid with qos 15 and 0 -> round-robin alternation 1,3,1,3. Separately, ARESETN asserted while grant_valid=1 -> grant_valid=0 asynchronously, before the next ACLK edge.

Source files
------------

// File: rtl/qos_rr_arbiter.sv
// QoS-aware round-robin arbiter for one AXI address channel.
// Highest effective QoS wins, ties rotate after the last winner, and aging promotes starved requesters.
module qos_rr_arbiter #(
  parameter int NUM_MASTERS = 4,
  parameter int ID_W        = $clog2(NUM_MASTERS),
  parameter int QOS_W       = 4,
  parameter int AGE_W       = 4,
  parameter int AGE_LIMIT   = 8,
  parameter bit QOS_EN      = 1'b1
) (
  input  logic                         ACLK,
  input  logic                         ARESETN,
  input  logic [NUM_MASTERS-1:0]       req_valid,
  input  logic [NUM_MASTERS*QOS_W-1:0] req_qos,
  input  logic                         grant_ready,
  output logic                         grant_valid,
  output logic [ID_W-1:0]              grant_id,
  output logic [NUM_MASTERS-1:0]       grant_onehot,
  output logic [NUM_MASTERS-1:0]       promoted
);

  typedef enum logic {ARB, GRANT} state_t;

  state_t                              state;
  state_t                              state_nxt;
  logic [NUM_MASTERS-1:0][AGE_W-1:0]   age;
  logic [NUM_MASTERS-1:0][QOS_W:0]     prio;
  logic [ID_W-1:0]                     rr_ptr;
  logic [ID_W-1:0]                     win_id;
  logic                                latch_grant;
  logic                                handshake;

  function automatic logic [AGE_W-1:0] age_sat_inc(input logic [AGE_W-1:0] a);
    if (a == {AGE_W{1'b1}}) return a;
    return a + 1'b1;
  endfunction

  function automatic logic [ID_W-1:0] wrap_id(input int v);
    return ID_W'(v % NUM_MASTERS);
  endfunction

  always_comb begin
    for (int i = 0; i < NUM_MASTERS; i++) begin
      promoted[i] = (age[i] >= AGE_W'(AGE_LIMIT));
    end
  end

  // Promotion outranks any QoS value by occupying the extra top bit.
  always_comb begin
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (promoted[i])
        prio[i] = {1'b1, {QOS_W{1'b0}}};
      else if (QOS_EN)
        prio[i] = {1'b0, req_qos[i*QOS_W +: QOS_W]};
      else
        prio[i] = '0;
    end
  end

  // Scan from rr_ptr; strict '>' keeps the earliest candidate on ties.
  always_comb begin
    logic [ID_W-1:0] idx;
    logic [QOS_W:0]  best;
    logic            found;
    win_id = rr_ptr;
    idx    = '0;
    best   = '0;
    found  = 1'b0;
    for (int k = 0; k < NUM_MASTERS; k++) begin
      idx = wrap_id(int'(rr_ptr) + k);
      if (req_valid[idx] && (!found || (prio[idx] > best))) begin
        found  = 1'b1;
        best   = prio[idx];
        win_id = idx;
      end
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) state <= ARB;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ARB:     if (|req_valid) state_nxt = GRANT;
      GRANT:   if (grant_valid && grant_ready) state_nxt = ARB;
      default: state_nxt = ARB;
    endcase
  end

  always_comb begin
    latch_grant = 1'b0;
    handshake   = 1'b0;
    case (state)
      ARB:     latch_grant = |req_valid;
      GRANT:   handshake   = grant_valid && grant_ready;
      default: ;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      grant_valid  <= 1'b0;
      grant_id     <= '0;
      grant_onehot <= '0;
      rr_ptr       <= '0;
    end else if (latch_grant) begin
      grant_valid  <= 1'b1;
      grant_id     <= win_id;
      grant_onehot <= NUM_MASTERS'(1) << win_id;
    end else if (handshake) begin
      grant_valid  <= 1'b0;
      grant_onehot <= '0;
      rr_ptr       <= wrap_id(int'(grant_id) + 1);
    end
  end

  // The granted master's age freezes while it holds the grant and clears on acceptance.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      age <= '0;
    end else begin
      for (int i = 0; i < NUM_MASTERS; i++) begin
        if (!req_valid[i])
          age[i] <= '0;
        else if (handshake && (grant_id == ID_W'(i)))
          age[i] <= '0;
        else if ((state == GRANT) && (grant_id == ID_W'(i)))
          age[i] <= age[i];
        else
          age[i] <= age_sat_inc(age[i]);
      end
    end
  end

endmodule

// File: tb/tb_qos_rr_arbiter.sv
// Self-checking bench for qos_rr_arbiter: QoS instance plus a pure round-robin instance.
module tb_qos_rr_arbiter;

  logic        clk = 1'b0;
  logic        rstn;
  logic [3:0]  req_valid;
  logic [15:0] req_qos;
  logic        grant_ready;
  logic        grant_valid;
  logic [1:0]  grant_id;
  logic [3:0]  grant_onehot;
  logic [3:0]  promoted;

  logic [3:0]  rr_req_valid;
  logic [15:0] rr_req_qos;
  logic        rr_grant_ready;
  logic        rr_grant_valid;
  logic [1:0]  rr_grant_id;
  logic [3:0]  rr_grant_onehot;
  logic [3:0]  rr_promoted;

  int errors = 0;
  int checks = 0;
  int exp_q[$];

  always #5 clk = ~clk;

  qos_rr_arbiter #(.NUM_MASTERS(4), .QOS_W(4), .AGE_W(4), .AGE_LIMIT(8), .QOS_EN(1'b1)) dut (
    .ACLK(clk), .ARESETN(rstn), .req_valid(req_valid), .req_qos(req_qos),
    .grant_ready(grant_ready), .grant_valid(grant_valid), .grant_id(grant_id),
    .grant_onehot(grant_onehot), .promoted(promoted)
  );

  qos_rr_arbiter #(.NUM_MASTERS(4), .QOS_W(4), .AGE_W(4), .AGE_LIMIT(8), .QOS_EN(1'b0)) dut_rr (
    .ACLK(clk), .ARESETN(rstn), .req_valid(rr_req_valid), .req_qos(rr_req_qos),
    .grant_ready(rr_grant_ready), .grant_valid(rr_grant_valid), .grant_id(rr_grant_id),
    .grant_onehot(rr_grant_onehot), .promoted(rr_promoted)
  );

  task automatic reset_dut();
    rstn = 1'b0;
    req_valid = '0; req_qos = '0; grant_ready = 1'b0;
    rr_req_valid = '0; rr_req_qos = '0; rr_grant_ready = 1'b0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic wait_grant(output bit seen);
    seen = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (grant_valid === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  task automatic do_handshake();
    grant_ready = 1'b1;
    @(posedge clk);
    #1 grant_ready = 1'b0;
  endtask

  task automatic test_reset();
    int exp_id;
    rstn = 1'b0; req_valid = 4'b1111; req_qos = {4{4'd5}}; grant_ready = 1'b0;
    rr_req_valid = '0; rr_req_qos = '0; rr_grant_ready = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (grant_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b want 0", grant_valid); end
    checks++; if (grant_id !== 2'd0) begin errors++; $display("FAIL rst_id: got %0d want 0", grant_id); end
    checks++; if (grant_onehot !== 4'b0000) begin errors++; $display("FAIL rst_onehot: got %b want 0000", grant_onehot); end
    checks++; if (promoted !== 4'b0000) begin errors++; $display("FAIL rst_promoted: got %b want 0000", promoted); end
    exp_q.push_back(0);
    rstn = 1'b1;
    @(negedge clk);
    exp_id = exp_q.pop_front();
    checks++; if (grant_valid !== 1'b1) begin errors++; $display("FAIL first_grant_latency: got %b want 1", grant_valid); end
    checks++; if (grant_id !== 2'(exp_id)) begin errors++; $display("FAIL first_grant_id: got %0d want %0d", grant_id, exp_id); end
    checks++; if (grant_onehot !== 4'b0001) begin errors++; $display("FAIL first_grant_onehot: got %b want 0001", grant_onehot); end
    do_handshake();
    req_valid = '0;
    @(negedge clk);
    checks++; if (grant_valid !== 1'b0) begin errors++; $display("FAIL release: got %b want 0", grant_valid); end
  endtask

  task automatic test_qos_priority();
    bit seen;
    int exp_id;
    reset_dut();
    req_qos = {4'd0, 4'd9, 4'd3, 4'd0};
    req_valid = 4'b0110;
    exp_q.push_back(2);
    exp_q.push_back(1);
    wait_grant(seen);
    exp_id = exp_q.pop_front();
    checks++; if (!seen || grant_id !== 2'(exp_id)) begin errors++; $display("FAIL qos_high: got %0d seen=%0d want %0d", grant_id, seen, exp_id); end
    do_handshake();
    req_valid = 4'b0010;
    @(negedge clk);
    checks++; if (grant_valid !== 1'b0) begin errors++; $display("FAIL qos_bubble: got %b want 0", grant_valid); end
    @(negedge clk);
    exp_id = exp_q.pop_front();
    checks++; if (grant_valid !== 1'b1 || grant_id !== 2'(exp_id)) begin errors++; $display("FAIL qos_second: got v=%b id=%0d want v=1 id=%0d", grant_valid, grant_id, exp_id); end
    do_handshake();
    req_valid = '0;
  endtask

  task automatic test_round_robin();
    bit seen;
    int exp_id;
    reset_dut();
    req_qos = {4{4'd5}};
    req_valid = 4'b1111;
    exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(2); exp_q.push_back(3); exp_q.push_back(0);
    for (int n = 0; n < 5; n++) begin
      wait_grant(seen);
      exp_id = exp_q.pop_front();
      checks++; if (!seen || grant_id !== 2'(exp_id)) begin errors++; $display("FAIL rr_order[%0d]: got %0d seen=%0d want %0d", n, grant_id, seen, exp_id); end
      checks++; if (grant_onehot !== (4'b0001 << exp_id)) begin errors++; $display("FAIL rr_onehot[%0d]: got %b want %b", n, grant_onehot, 4'b0001 << exp_id); end
      do_handshake();
    end
    req_valid = '0;
  endtask

  task automatic test_hold();
    bit seen;
    int exp_id;
    reset_dut();
    req_qos = {4{4'd5}};
    req_valid = 4'b1111;
    exp_q.push_back(0);
    exp_q.push_back(1);
    wait_grant(seen);
    exp_id = exp_q.pop_front();
    checks++; if (!seen || grant_id !== 2'(exp_id)) begin errors++; $display("FAIL hold_first: got %0d want %0d", grant_id, exp_id); end
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      checks++;
      if (grant_valid !== 1'b1 || grant_id !== 2'd0 || grant_onehot !== 4'b0001) begin
        errors++;
        $display("FAIL hold_stable[%0d]: got v=%b id=%0d oh=%b want v=1 id=0 oh=0001", c, grant_valid, grant_id, grant_onehot);
      end
    end
    do_handshake();
    wait_grant(seen);
    exp_id = exp_q.pop_front();
    checks++; if (!seen || grant_id !== 2'(exp_id)) begin errors++; $display("FAIL hold_next: got %0d want %0d", grant_id, exp_id); end
    do_handshake();
    req_valid = '0;
  endtask

  task automatic test_aging();
    int  exp_id;
    bit  exp_v;
    bit  exp_p;
    reset_dut();
    req_qos = {4'd0, 4'd0, 4'd0, 4'd15};
    req_valid = 4'b1001;
    grant_ready = 1'b1;
    exp_q.push_back(0); exp_q.push_back(0); exp_q.push_back(0); exp_q.push_back(0); exp_q.push_back(3);
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      exp_v = (k % 2) == 1;
      exp_p = (k == 8) || (k == 9);
      checks++; if (grant_valid !== exp_v) begin errors++; $display("FAIL age_valid[%0d]: got %b want %b", k, grant_valid, exp_v); end
      if (grant_valid === 1'b1 && exp_v) begin
        exp_id = exp_q.pop_front();
        checks++; if (grant_id !== 2'(exp_id)) begin errors++; $display("FAIL age_grant[%0d]: got %0d want %0d", k, grant_id, exp_id); end
      end
      checks++; if (promoted[3] !== exp_p) begin errors++; $display("FAIL age_promoted3[%0d]: got %b want %b", k, promoted[3], exp_p); end
    end
    grant_ready = 1'b0;
    req_valid = '0;
    exp_q.delete();
  endtask

  task automatic test_no_qos();
    int exp_id;
    bit exp_v;
    reset_dut();
    rr_req_qos = {4'd0, 4'd0, 4'd15, 4'd0};
    rr_req_valid = 4'b1010;
    rr_grant_ready = 1'b1;
    exp_q.push_back(1); exp_q.push_back(3); exp_q.push_back(1); exp_q.push_back(3);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      exp_v = (k % 2) == 1;
      checks++; if (rr_grant_valid !== exp_v) begin errors++; $display("FAIL noqos_valid[%0d]: got %b want %b", k, rr_grant_valid, exp_v); end
      if (exp_v) begin
        exp_id = exp_q.pop_front();
        checks++; if (rr_grant_id !== 2'(exp_id)) begin errors++; $display("FAIL noqos_grant[%0d]: got %0d want %0d", k, rr_grant_id, exp_id); end
      end
    end
    rr_grant_ready = 1'b0;
    rr_req_valid = '0;
  endtask

  task automatic test_async_reset();
    bit seen;
    reset_dut();
    req_qos = '0;
    req_valid = 4'b0100;
    wait_grant(seen);
    checks++; if (!seen || grant_id !== 2'd2) begin errors++; $display("FAIL areset_pre: got %0d want 2", grant_id); end
    #2 rstn = 1'b0;
    #1;
    checks++; if (grant_valid !== 1'b0) begin errors++; $display("FAIL areset_valid: got %b want 0", grant_valid); end
    checks++; if (grant_onehot !== 4'b0000 || grant_id !== 2'd0) begin errors++; $display("FAIL areset_id: got id=%0d oh=%b want 0/0000", grant_id, grant_onehot); end
    @(negedge clk);
    req_valid = '0;
    rstn = 1'b1;
  endtask

  initial begin
    test_reset();
    test_qos_priority();
    test_round_robin();
    test_hold();
    test_aging();
    test_no_qos();
    test_async_reset();
    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
